// File: rtl/pio_pkg.sv
// Shared constants for the PIO loader: command codes, config-entry field
// layout, load-sequence states and the machine-select width helper.
package pio_pkg;

  // Command codes understood by the pio command port.
  localparam logic [3:0] ACT_NONE  = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PUSH  = 4'd4;

  // Config ROM entry layout: {mindex, action[3:0], data[31:0]}.
  localparam int CONF_DATA_W   = 32;
  localparam int CONF_ACT_LSB  = 32;
  localparam int CONF_ACT_W    = 4;
  localparam int CONF_MIDX_LSB = 36;

  // Load sequence: program words, then config entries, then streaming.
  typedef enum logic [1:0] {
    LOAD_PROG = 2'd0,
    LOAD_CONF = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Width of a state-machine select; a single machine still needs one bit.
  function automatic int midx_w(input int num_sm);
    return (num_sm > 1) ? $clog2(num_sm) : 1;
  endfunction

endpackage

// File: rtl/pio_rate_tick.sv
// Push-interval counter: tick is high whenever the count is 0. The count
// runs 0..rate and reloads; a new rate is picked up only at a reload (or
// while held in clear), so an interval in progress is never stretched.
module pio_rate_tick #(
  parameter int RATE_W = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  logic [RATE_W-1:0] cnt;
  logic [RATE_W-1:0] rate_q;

  // Interval count with synchronous clear and rate capture at each reload.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      rate_q <= '0;
    end else if (clear) begin
      cnt    <= '0;
      rate_q <= rate;
    end else if (cnt >= rate_q) begin
      cnt    <= '0;
      rate_q <= rate;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/pio_loader.sv
// Boots one PIO: streams PROG_LEN instruction words from the program ROM,
// then CONF_LEN commands from the config ROM, then pushes data words into a
// state machine TX FIFO, either from an upstream stream (MODE 0) or from an
// internal 0,1,0,1 toggle (MODE 1). Both ROMs have one cycle of latency, so
// the command for an address is presented one cycle after that address;
// the command outputs are therefore a mux of registered strobe flags and
// the ROM data arriving in the same cycle.
module pio_loader
  import pio_pkg::*;
#(
  parameter  int PROG_LEN = 32,
  parameter  int CONF_LEN = 5,
  parameter  int NUM_SM   = 4,
  parameter  int RATE_W   = 22,
  parameter  int MODE     = 0,
  localparam int MIDX_W   = midx_w(NUM_SM)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic [RATE_W-1:0]    rate,
  output logic [4:0]           prog_addr,
  input  logic [15:0]          prog_data,
  output logic [4:0]           conf_addr,
  input  logic [36+MIDX_W-1:0] conf_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_data,
  input  logic [MIDX_W-1:0]    s_mindex,
  input  logic [NUM_SM-1:0]    tx_full,
  output logic [3:0]           action,
  output logic [4:0]           index,
  output logic [31:0]          din,
  output logic [MIDX_W-1:0]    mindex,
  output logic                 running,
  output logic [31:0]          push_count
);

  localparam logic [4:0] PROG_LAST = 5'(PROG_LEN - 1);
  localparam logic [5:0] CONF_END  = 6'(CONF_LEN);

  state_t            state;
  logic [5:0]        conf_cnt;     // entries issued; one wider than the address
  logic [4:0]        idx_q;        // instruction index of the pending strobe
  logic              prog_vld_q;   // instruction data arrives this cycle
  logic              conf_vld_q;   // config entry arrives this cycle
  logic              push_q;       // push decided last cycle
  logic [31:0]       push_din_q;
  logic [MIDX_W-1:0] push_midx_q;
  logic              val_q;        // toggle generator value
  logic              tick;
  logic              push_go;
  logic [31:0]       push_word;
  logic [MIDX_W-1:0] push_sm;
  logic [3:0]        conf_act;

  assign running   = (state == RUN);
  assign conf_addr = conf_cnt[4:0];
  assign conf_act  = conf_data[CONF_ACT_LSB +: CONF_ACT_W];

  pio_rate_tick #(
    .RATE_W (RATE_W)
  ) u_rate_tick (
    .clk   (clk),
    .reset (reset),
    .clear (~running | restart),
    .rate  (rate),
    .tick  (tick)
  );

  // Push decision for this cycle; a restart drops any transfer it overlaps.
  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    s_ready   = 1'b0;
    push_go   = 1'b0;
    push_word = '0;
    push_sm   = '0;
    if (MODE == 0) begin
      s_ready   = running & tick & ~tx_full[s_mindex] & ~restart & ~reset;
      push_go   = s_valid & s_ready;
      push_word = s_data;
      push_sm   = s_mindex;
    end else begin
      push_go   = running & tick & ~tx_full[0] & ~restart & ~reset;
      push_word = {31'b0, val_q};
    end
  end

  // Load sequencer, push pipeline and counters; restart behaves as a reset
  // of everything except the interval counter, which clears via its own port.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state       <= LOAD_PROG;
      prog_addr   <= '0;
      conf_cnt    <= '0;
      idx_q       <= '0;
      prog_vld_q  <= 1'b0;
      conf_vld_q  <= 1'b0;
      push_q      <= 1'b0;
      push_din_q  <= '0;
      push_midx_q <= '0;
      val_q       <= 1'b0;
      push_count  <= '0;
    end else begin
      prog_vld_q <= 1'b0;
      conf_vld_q <= 1'b0;
      push_q     <= 1'b0;
      case (state)
        LOAD_PROG: begin
          prog_vld_q <= 1'b1;
          idx_q      <= prog_addr;
          if (prog_addr == PROG_LAST) state <= LOAD_CONF;
          else                        prog_addr <= prog_addr + 5'd1;
        end
        LOAD_CONF: begin
          // The cycle after the last address drains the final entry.
          if (conf_cnt == CONF_END) begin
            state <= RUN;
          end else begin
            conf_vld_q <= 1'b1;
            conf_cnt   <= conf_cnt + 6'd1;
          end
        end
        RUN: begin
          if (push_go) begin
            push_q      <= 1'b1;
            push_din_q  <= push_word;
            push_midx_q <= push_sm;
            if (push_count != '1) push_count <= push_count + 32'd1;
            if (MODE != 0) val_q <= ~val_q;
          end
        end
        default: state <= LOAD_PROG;
      endcase
    end
  end

  // Command port: at most one source is pending in any cycle; zero-action
  // config entries consume their slot without a strobe.
  always_comb begin
    action = ACT_NONE;
    index  = '0;
    din    = '0;
    mindex = '0;
    if (!reset && !restart) begin
      if (prog_vld_q) begin
        action = ACT_INSTR;
        index  = idx_q;
        din    = {16'b0, prog_data};
      end else if (conf_vld_q && conf_act != ACT_NONE) begin
        action = conf_act;
        din    = conf_data[CONF_DATA_W-1:0];
        mindex = conf_data[CONF_MIDX_LSB +: MIDX_W];
      end else if (push_q) begin
        action = ACT_PUSH;
        din    = push_din_q;
        mindex = push_midx_q;
      end
    end
  end

endmodule

// File: tb/tb_pio_loader.sv
// Bench for pio_loader: one instance in stream mode, one in toggle mode,
// sharing clock, reset and restart. A driver applies stimulus and a
// cycle-level reference model queues the expected commands; a monitor on
// the falling edge pops and compares.
module tb_pio_loader;
  import pio_pkg::*;

  localparam int PROG_LEN  = 32;
  localparam int CONF_LEN  = 5;
  localparam int RUN_START = PROG_LEN + CONF_LEN + 1;

  typedef struct {
    logic [3:0]  act;
    logic [4:0]  idx;
    bit          chk_idx;
    logic [31:0] din;
    logic [1:0]  midx;
    int          due;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, restart = 1'b0;
  logic [21:0] rate0 = 22'd0, rate1 = 22'd3;
  logic [4:0]  prog_addr0, prog_addr1, conf_addr0, conf_addr1;
  logic [15:0] prog_data0, prog_data1;
  logic [37:0] conf_data0, conf_data1;
  logic        s_valid0 = 1'b0, s_valid1 = 1'b0, s_ready0, s_ready1;
  logic [31:0] s_data0 = '0, s_data1 = '0;
  logic [1:0]  s_mindex0 = '0, s_mindex1 = '0;
  logic [3:0]  tx_full0 = '0, tx_full1 = '0;
  logic [3:0]  act0, act1;
  logic [4:0]  idx0, idx1;
  logic [31:0] din0, din1;
  logic [1:0]  midx0, midx1;
  logic        running0, running1;
  logic [31:0] pcnt0, pcnt1;

  always #5 clk = ~clk;

  pio_loader #(.PROG_LEN(PROG_LEN), .CONF_LEN(CONF_LEN), .NUM_SM(4), .RATE_W(22), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .restart(restart), .rate(rate0),
    .prog_addr(prog_addr0), .prog_data(prog_data0), .conf_addr(conf_addr0), .conf_data(conf_data0),
    .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0), .s_mindex(s_mindex0), .tx_full(tx_full0),
    .action(act0), .index(idx0), .din(din0), .mindex(midx0), .running(running0), .push_count(pcnt0));

  pio_loader #(.PROG_LEN(PROG_LEN), .CONF_LEN(CONF_LEN), .NUM_SM(4), .RATE_W(22), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .restart(restart), .rate(rate1),
    .prog_addr(prog_addr1), .prog_data(prog_data1), .conf_addr(conf_addr1), .conf_data(conf_data1),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1), .s_mindex(s_mindex1), .tx_full(tx_full1),
    .action(act1), .index(idx1), .din(din1), .mindex(midx1), .running(running1), .push_count(pcnt1));

  // Synchronous ROMs with one cycle of latency.
  logic [15:0] prog_rom [32];
  logic [37:0] conf_rom [32];
  always @(posedge clk) begin
    prog_data0 <= prog_rom[prog_addr0];
    prog_data1 <= prog_rom[prog_addr1];
    conf_data0 <= conf_rom[conf_addr0];
    conf_data1 <= conf_rom[conf_addr1];
  end

  // Scoreboard and per-cycle expectations written by the driver.
  cmd_t        q0[$], q1[$];
  int          vectors = 0, miscompares = 0;
  int          abs_cyc = 0, cyc = 0;
  bit          clr_prev = 1'b1;
  bit          exp_chk = 1'b0, exp_running = 1'b0, exp_ready0 = 1'b0;
  logic [31:0] exp_pc0 = '0, exp_pc1 = '0, m_pc0 = '0, m_pc1 = '0;
  logic [4:0]  exp_paddr = '0, exp_caddr = '0;
  bit          m_val = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, abs_cyc, actual, expected);
    end
  endtask

  task automatic mon_dut(input int d, input logic [3:0] a, input logic [4:0] ix,
                         input logic [31:0] dn, input logic [1:0] mi);
    cmd_t e;
    bit   have = 1'b0;
    if (d == 0) begin
      if (q0.size() > 0 && q0[0].due == abs_cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == abs_cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    if (have) begin
      check($sformatf("dut%0d action", d), a, e.act);
      check($sformatf("dut%0d din", d), dn, e.din);
      check($sformatf("dut%0d mindex", d), mi, e.midx);
      if (e.chk_idx) check($sformatf("dut%0d index", d), ix, e.idx);
    end else begin
      check($sformatf("dut%0d idle action", d), a, ACT_NONE);
    end
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon_dut(0, act0, idx0, din0, midx0);
    mon_dut(1, act1, idx1, din1, midx1);
    check("dut0 s_ready", s_ready0, exp_ready0);
    check("dut1 s_ready", s_ready1, 1'b0);
    if (exp_chk) begin
      check("dut0 running", running0, exp_running);
      check("dut1 running", running1, exp_running);
      check("dut0 push_count", pcnt0, exp_pc0);
      check("dut1 push_count", pcnt1, exp_pc1);
      check("dut0 prog_addr", prog_addr0, exp_paddr);
      check("dut1 prog_addr", prog_addr1, exp_paddr);
      check("dut0 conf_addr", conf_addr0, exp_caddr);
      check("dut1 conf_addr", conf_addr1, exp_caddr);
      if (cyc == 0) begin
        check("dut0 reset index", idx0, 5'd0);
        check("dut0 reset din", din0, 32'd0);
        check("dut0 reset mindex", midx0, 2'd0);
        check("dut1 reset index", idx1, 5'd0);
        check("dut1 reset din", din1, 32'd0);
        check("dut1 reset mindex", midx1, 2'd0);
      end
    end
  end

  task automatic push_both(input cmd_t e);
    q0.push_back(e);
    q1.push_back(e);
  endtask

  // Reference model: expected behaviour of this cycle from the load
  // schedule and interval arithmetic, given the inputs just applied.
  task automatic model();
    cmd_t e;
    int   t;
    exp_chk = !(reset || restart);
    if (reset || restart) begin
      q0.delete();
      q1.delete();
      m_pc0 = '0;
      m_pc1 = '0;
      m_val = 1'b0;
      exp_ready0 = 1'b0;
      return;
    end
    exp_pc0     = m_pc0;
    exp_pc1     = m_pc1;
    exp_paddr   = (cyc < PROG_LEN) ? 5'(cyc) : 5'(PROG_LEN - 1);
    exp_caddr   = (cyc <= PROG_LEN) ? 5'd0 :
                  ((cyc - PROG_LEN < CONF_LEN) ? 5'(cyc - PROG_LEN) : 5'(CONF_LEN));
    exp_running = (cyc >= RUN_START);
    exp_ready0  = 1'b0;
    if (cyc == 0) begin
      for (int k = 0; k < PROG_LEN; k++) begin
        e = '{act: ACT_INSTR, idx: 5'(k), chk_idx: 1'b1, din: {16'b0, prog_rom[k]},
              midx: 2'd0, due: abs_cyc + k + 1};
        push_both(e);
      end
      for (int j = 0; j < CONF_LEN; j++) begin
        if (conf_rom[j][35:32] != 4'd0) begin
          e = '{act: conf_rom[j][35:32], idx: 5'd0, chk_idx: 1'b0, din: conf_rom[j][31:0],
                midx: conf_rom[j][37:36], due: abs_cyc + PROG_LEN + 1 + j};
          push_both(e);
        end
      end
    end
    if (exp_running) begin
      t = cyc - RUN_START;
      exp_ready0 = ((t % (int'(rate0) + 1)) == 0) && !tx_full0[s_mindex0];
      if (exp_ready0 && s_valid0) begin
        e = '{act: ACT_PUSH, idx: 5'd0, chk_idx: 1'b0, din: s_data0, midx: s_mindex0, due: abs_cyc + 1};
        q0.push_back(e);
        m_pc0++;
      end
      if (((t % (int'(rate1) + 1)) == 0) && !tx_full1[0]) begin
        e = '{act: ACT_PUSH, idx: 5'd0, chk_idx: 1'b0, din: {31'b0, m_val}, midx: 2'd0, due: abs_cyc + 1};
        q1.push_back(e);
        m_val = ~m_val;
        m_pc1++;
      end
    end
  endtask

  // Stimulus policy per cycle of the load/run sequence.
  task automatic drive_inputs();
    s_data0   = $urandom;
    s_data1   = $urandom;
    s_valid1  = 1'($urandom_range(0, 1));
    s_mindex1 = 2'($urandom_range(0, 3));
    if (cyc < RUN_START + 8) begin
      s_valid0 = 1'b1; s_mindex0 = 2'd2; tx_full0 = 4'b0100;
    end else if (cyc < RUN_START + 16) begin
      s_valid0 = 1'b1; s_mindex0 = 2'd2; tx_full0 = 4'b0000;
    end else begin
      s_valid0  = ($urandom_range(0, 3) != 0);
      s_mindex0 = 2'($urandom_range(0, 3));
      tx_full0  = 4'($urandom) & 4'($urandom);
    end
    tx_full1[3:1] = 3'($urandom);
    tx_full1[0]   = (cyc >= RUN_START + 13) && (cyc < RUN_START + 23);
  endtask

  task automatic run_cycle(input bit rst, input bit rs);
    @(posedge clk);
    #1;
    abs_cyc++;
    cyc      = clr_prev ? 0 : cyc + 1;
    reset    = rst;
    restart  = rs;
    drive_inputs();
    model();
    clr_prev = rst | rs;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      prog_rom[k] = 16'hA000 + 16'(k);
      conf_rom[k] = {2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), 32'($urandom)};
    end
    conf_rom[2][35:32] = 4'd0;

    repeat (2) run_cycle(1'b1, 1'b0);
    repeat (100) run_cycle(1'b0, 1'b0);        // boot and 62 cycles of RUN
    run_cycle(1'b0, 1'b1);                     // restart during RUN
    repeat (PROG_LEN + 3) run_cycle(1'b0, 1'b0);
    rate0 = 22'd1;
    rate1 = 22'd2;
    run_cycle(1'b0, 1'b1);                     // restart mid LOAD_CONF
    repeat (20) run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b1);                     // reset with restart at cycle 20
    repeat (90) run_cycle(1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
